// File: rtl/eeprom_arbiter_pkg.sv
// eeprom_arbiter_pkg
//   Shared types and limits for the EEPROM read arbiter:
//   - state_t : arbiter FSM states (idle, access in progress, bus turnaround)
//   - cnt_t   : 4-bit wait/turnaround counter
//   - WAIT_MAX / TURN_MAX : legal upper bounds of the WAIT and TURN parameters
package eeprom_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_TURN
   } state_t;

   typedef logic [3:0] cnt_t;

   localparam int WAIT_MAX = 15;
   localparam int TURN_MAX = 3;

endpackage

// File: rtl/eeprom_arbiter_rr.sv
// rr_arbiter2
//   Two-way round-robin pick, purely combinational.
//   Ports:
//     REQ    [1:0] in   per-port request
//     LAST         in   most recently granted port
//     WINNER [1:0] out  one-hot winner (zero when nobody requests)
//     VALID        out  at least one port is requesting
module rr_arbiter2 (
   input  logic [1:0] REQ,
   input  logic       LAST,
   output logic [1:0] WINNER,
   output logic       VALID
);

   always_comb begin
      WINNER = '0;
      case (REQ)
         2'b01:   WINNER = 2'b01;
         2'b10:   WINNER = 2'b10;
         // tie: the port that did not win last time goes first
         2'b11:   WINNER = LAST ? 2'b01 : 2'b10;
         default: WINNER = '0;
      endcase
   end

   assign VALID = |REQ;

endmodule

// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter
//   Shares one asynchronous parallel EEPROM between two read requesters.
//   Round-robin arbitration, address held stable for the whole access,
//   ROM_N_OE low for WAIT cycles, data captured, then TURN idle cycles.
//   Ports:
//     CLK, N_RST        clock, asynchronous active-low reset
//     REQ[1:0]          per-port read request
//     ADDR0, ADDR1      per-port read address
//     GNT[1:0]          one-cycle pulse: request accepted, address latched
//     RVALID[1:0]       one-cycle pulse: RDATA holds that port's data
//     RDATA             last captured data
//     BUSY              high during access and turnaround
//     ROM_ADDR          registered EEPROM address
//     ROM_N_OE          registered EEPROM output enable (active low)
//     ROM_DATA          EEPROM data pins
module eeprom_arbiter
   import eeprom_arbiter_pkg::*;
#(
   parameter int DEPTH = 17,
   parameter int WIDTH = 8,
   parameter int WAIT  = 3,
   parameter int TURN  = 1
) (
   input  logic             CLK,
   input  logic             N_RST,
   input  logic [1:0]       REQ,
   input  logic [DEPTH-1:0] ADDR0,
   input  logic [DEPTH-1:0] ADDR1,
   output logic [1:0]       GNT,
   output logic [1:0]       RVALID,
   output logic [WIDTH-1:0] RDATA,
   output logic             BUSY,
   output logic [DEPTH-1:0] ROM_ADDR,
   output logic             ROM_N_OE,
   input  logic [WIDTH-1:0] ROM_DATA
);

   generate
      if (WAIT < 1 || WAIT > WAIT_MAX) begin : g_bad_wait
         $error("eeprom_arbiter: WAIT must be in 1..15");
      end
      if (TURN < 0 || TURN > TURN_MAX) begin : g_bad_turn
         $error("eeprom_arbiter: TURN must be in 0..3");
      end
   endgenerate

   localparam cnt_t CNT_WAIT = cnt_t'(WAIT - 1);
   localparam cnt_t CNT_TURN = cnt_t'((TURN > 0) ? TURN - 1 : 0);

   state_t           r_state;
   cnt_t             r_cnt;
   logic             r_last;
   logic [1:0]       r_gnt;
   logic [1:0]       r_rvalid;
   logic [WIDTH-1:0] r_rdata;
   logic             r_busy;
   logic [DEPTH-1:0] r_addr;
   logic             r_n_oe;

   logic [1:0]       w_winner;
   logic             w_valid;

   rr_arbiter2 u_rr (
      .REQ    (REQ),
      .LAST   (r_last),
      .WINNER (w_winner),
      .VALID  (w_valid)
   );

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_last   <= 1'b1;
         r_gnt    <= '0;
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_busy   <= 1'b0;
         r_addr   <= '0;
         r_n_oe   <= 1'b1;
      end else begin
         r_gnt    <= '0;
         r_rvalid <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  // r_last doubles as the port owning the access in flight
                  r_last  <= w_winner[1];
                  r_addr  <= w_winner[1] ? ADDR1 : ADDR0;
                  r_gnt   <= w_winner;
                  r_n_oe  <= 1'b0;
                  r_cnt   <= CNT_WAIT;
                  r_busy  <= 1'b1;
                  r_state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - cnt_t'(1);
               end else begin
                  r_rdata  <= ROM_DATA;
                  r_rvalid <= {r_last, ~r_last};
                  r_n_oe   <= 1'b1;
                  if (TURN == 0) begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt   <= CNT_TURN;
                     r_state <= ST_TURN;
                  end
               end
            end
            ST_TURN: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - cnt_t'(1);
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_n_oe  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign GNT      = r_gnt;
   assign RVALID   = r_rvalid;
   assign RDATA    = r_rdata;
   assign BUSY     = r_busy;
   assign ROM_ADDR = r_addr;
   assign ROM_N_OE = r_n_oe;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb_eeprom_arbiter
//   Two arbiter instances (WAIT=3/TURN=1 and WAIT=1/TURN=0) driven from one
//   clock, compared every cycle against a timeline model: each accepted
//   request opens an access window [g, g+WAIT+TURN) computed arithmetically.
module tb_eeprom_arbiter;

   localparam int DEPTH = 17;
   localparam int WIDTH = 8;
   localparam int W0 = 3, T0 = 1;
   localparam int W1 = 1, T1 = 0;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   logic [1:0]       req      [2];
   logic [DEPTH-1:0] addr0    [2];
   logic [DEPTH-1:0] addr1    [2];
   logic [1:0]       gnt      [2];
   logic [1:0]       rvalid   [2];
   logic [WIDTH-1:0] rdata    [2];
   logic             busy     [2];
   logic [DEPTH-1:0] rom_addr [2];
   logic             rom_n_oe [2];
   logic [WIDTH-1:0] rom_data [2];

   // EEPROM model: data only driven while output enable is asserted
   function automatic logic [WIDTH-1:0] rom_fn(input logic [DEPTH-1:0] a);
      if (a == 17'h1ABCD) return 8'h5A;
      return a[7:0] ^ a[15:8] ^ {7'h0, a[16]} ^ 8'hC3;
   endfunction

   assign rom_data[0] = rom_n_oe[0] ? '0 : rom_fn(rom_addr[0]);
   assign rom_data[1] = rom_n_oe[1] ? '0 : rom_fn(rom_addr[1]);

   eeprom_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WAIT(W0), .TURN(T0)) u_dut (
      .CLK(clk), .N_RST(n_rst), .REQ(req[0]), .ADDR0(addr0[0]), .ADDR1(addr1[0]),
      .GNT(gnt[0]), .RVALID(rvalid[0]), .RDATA(rdata[0]), .BUSY(busy[0]),
      .ROM_ADDR(rom_addr[0]), .ROM_N_OE(rom_n_oe[0]), .ROM_DATA(rom_data[0])
   );

   eeprom_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WAIT(W1), .TURN(T1)) u_dut_fast (
      .CLK(clk), .N_RST(n_rst), .REQ(req[1]), .ADDR0(addr0[1]), .ADDR1(addr1[1]),
      .GNT(gnt[1]), .RVALID(rvalid[1]), .RDATA(rdata[1]), .BUSY(busy[1]),
      .ROM_ADDR(rom_addr[1]), .ROM_N_OE(rom_n_oe[1]), .ROM_DATA(rom_data[1])
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int               mw      [2] = '{W0, W1};
   int               mt      [2] = '{T0, T1};
   bit               has_t   [2];
   int               g       [2];
   bit               p       [2];
   bit               m_last  [2];
   logic [DEPTH-1:0] m_addr  [2];
   logic [WIDTH-1:0] m_data  [2];
   logic [WIDTH-1:0] m_rdata [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         has_t[i] = 0; g[i] = 0; p[i] = 0; m_last[i] = 1;
         m_addr[i] = '0; m_data[i] = '0; m_rdata[i] = '0;
      end
   endtask

   // request value seen at the edge ending cycle cyc
   task automatic model_sample(input int i);
      bit busy_now;
      bit win;
      busy_now = has_t[i] && (cyc < g[i] + mw[i] + mt[i]);
      if (!busy_now && req[i] != 2'b00) begin
         win       = (req[i] == 2'b11) ? !m_last[i] : req[i][1];
         m_last[i] = win;
         p[i]      = win;
         g[i]      = cyc + 1;
         has_t[i]  = 1;
         m_addr[i] = win ? addr1[i] : addr0[i];
         m_data[i] = rom_fn(m_addr[i]);
      end
   endtask

   task automatic model_check(input int i);
      logic [1:0] e_gnt, e_rv;
      logic       e_noe, e_busy;
      e_gnt = '0; e_rv = '0; e_noe = 1'b1; e_busy = 1'b0;
      if (has_t[i]) begin
         if (cyc == g[i]) e_gnt = p[i] ? 2'b10 : 2'b01;
         if (cyc >= g[i] && cyc < g[i] + mw[i]) e_noe = 1'b0;
         if (cyc == g[i] + mw[i]) begin
            e_rv = p[i] ? 2'b10 : 2'b01;
            m_rdata[i] = m_data[i];
         end
         if (cyc >= g[i] && cyc < g[i] + mw[i] + mt[i]) e_busy = 1'b1;
      end
      check($sformatf("d%0d c%0d gnt", i, cyc), 32'(gnt[i]), 32'(e_gnt));
      check($sformatf("d%0d c%0d rvalid", i, cyc), 32'(rvalid[i]), 32'(e_rv));
      check($sformatf("d%0d c%0d n_oe", i, cyc), 32'(rom_n_oe[i]), 32'(e_noe));
      check($sformatf("d%0d c%0d busy", i, cyc), 32'(busy[i]), 32'(e_busy));
      check($sformatf("d%0d c%0d rom_addr", i, cyc), 32'(rom_addr[i]), 32'(m_addr[i]));
      check($sformatf("d%0d c%0d rdata", i, cyc), 32'(rdata[i]), 32'(m_rdata[i]));
   endtask

   // called at a falling edge with stimulus already applied; returns at the
   // next falling edge after checking the new cycle
   task automatic tick();
      for (int i = 0; i < 2; i++) model_sample(i);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) model_check(i);
   endtask

   task automatic drive(input logic [1:0] r, input logic [DEPTH-1:0] a0, input logic [DEPTH-1:0] a1);
      for (int i = 0; i < 2; i++) begin
         req[i] = r; addr0[i] = a0; addr1[i] = a1;
      end
   endtask

   task automatic idle_cycles(input int n);
      drive(2'b00, addr0[0], addr1[0]);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_rst = 1'b0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 2; i++) model_check(i);
      n_rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   int          gc [$];
   logic [1:0]  gv [$];

   initial begin
      n_rst = 1'b0;
      drive(2'b00, '0, '0);
      model_reset();
      do_reset();

      // 1: single read on port 0
      drive(2'b01, 17'h1ABCD, 17'h0);
      tick();                                        // cycle 1
      check("t1 gnt", 32'(gnt[0]), 32'h1);
      check("t1 noe c1", 32'(rom_n_oe[0]), 32'h0);
      check("t1 addr", 32'(rom_addr[0]), 32'h1ABCD);
      drive(2'b00, 17'h1ABCD, 17'h0);
      tick(); tick();                                // cycle 3
      check("t1 noe c3", 32'(rom_n_oe[0]), 32'h0);
      tick();                                        // cycle 4
      check("t1 rvalid", 32'(rvalid[0]), 32'h1);
      check("t1 rdata", 32'(rdata[0]), 32'h5A);
      check("t1 noe c4", 32'(rom_n_oe[0]), 32'h1);
      tick(); tick();                                // cycle 6
      check("t1 busy c6", 32'(busy[0]), 32'h0);
      idle_cycles(3);

      // 2: constant tie, grants alternate starting with port 0
      do_reset();
      drive(2'b11, 17'h00010, 17'h00020);
      for (int k = 0; k < 22; k++) begin
         tick();
         if (gnt[0] != 2'b00) begin
            gc.push_back(cyc); gv.push_back(gnt[0]);
            check("t2 rom_addr", 32'(rom_addr[0]), gnt[0][1] ? 32'h20 : 32'h10);
         end
      end
      check("t2 ngrants", 32'(gc.size() >= 4), 32'h1);
      if (gc.size() >= 4) begin
         for (int k = 0; k < 4; k++)
            check($sformatf("t2 grant%0d", k), 32'(gv[k]), k[0] ? 32'h2 : 32'h1);
         for (int k = 1; k < 4; k++)
            check($sformatf("t2 spacing%0d", k), 32'(gc[k] - gc[k-1]), 32'd5);
      end
      idle_cycles(8);

      // 3: port 1 requests while port 0 access is in progress
      drive(2'b01, 17'h00100, 17'h00200);
      tick();                                        // cycle 1
      check("t3 gnt c1", 32'(gnt[0]), 32'h1);
      check("t3 addr c1", 32'(rom_addr[0]), 32'h100);
      drive(2'b00, 17'h00100, 17'h00200);
      tick();                                        // cycle 2
      drive(2'b10, 17'h00100, 17'h00200);
      for (int c = 3; c <= 6; c++) begin
         tick();
         if (c < 6) check($sformatf("t3 gnt c%0d", c), 32'(gnt[0]), 32'h0);
         if (c <= 4) check($sformatf("t3 addr c%0d", c), 32'(rom_addr[0]), 32'h100);
         if (c == 6) begin
            check("t3 gnt c6", 32'(gnt[0]), 32'h2);
            check("t3 addr c6", 32'(rom_addr[0]), 32'h200);
         end
      end
      idle_cycles(8);

      // 4: reset in the middle of an access
      drive(2'b01, 17'h01234, 17'h04321);
      tick();
      drive(2'b00, 17'h01234, 17'h04321);
      tick();                                        // cycle 2
      #1 n_rst = 1'b0;
      #1;
      check("t4 noe async", 32'(rom_n_oe[0]), 32'h1);
      model_reset();
      for (int i = 0; i < 2; i++) model_check(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) model_check(i);
      @(negedge clk);
      n_rst = 1'b1;
      drive(2'b11, 17'h00AAA, 17'h00BBB);
      tick();
      check("t4 first tie d0", 32'(gnt[0]), 32'h1);
      check("t4 first tie d1", 32'(gnt[1]), 32'h1);
      idle_cycles(8);

      // 5: WAIT=1/TURN=0 back-to-back on port 0
      drive(2'b01, 17'h00777, 17'h0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         check($sformatf("t5 noe c%0d", c), 32'(rom_n_oe[1]), c[0] ? 32'h0 : 32'h1);
         check($sformatf("t5 gnt c%0d", c), 32'(gnt[1]), c[0] ? 32'h1 : 32'h0);
      end
      idle_cycles(8);

      // 6: request withdrawn before any sampling edge
      drive(2'b10, 17'h0, 17'h00555);
      #2;
      drive(2'b00, 17'h0, 17'h00555);
      tick();
      check("t6 gnt", 32'(gnt[0]), 32'h0);
      check("t6 busy", 32'(busy[0]), 32'h0);
      tick();
      check("t6 busy2", 32'(busy[0]), 32'h0);

      // randomized traffic, independent per instance
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 2) == 0) req[i] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr0[i] = DEPTH'($urandom);
            if ($urandom_range(0, 3) == 0) addr1[i] = DEPTH'($urandom);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
